// File: rtl/rbz_spi_pkg.sv
// Shared definitions for the Wishbone SPI register master: register map, field positions, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package rbz_spi_pkg;

    // Register offsets, indexed by adr[3:2]
    localparam logic [1:0] OFS_DATA   = 2'd0;
    localparam logic [1:0] OFS_CTRL   = 2'd1;
    localparam logic [1:0] OFS_STATUS = 2'd2;

    // CTRL field positions
    localparam int CTRL_TGT   = 8;
    localparam int CTRL_IE    = 9;
    localparam int CTRL_START = 31;

    // STATUS field positions
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVR  = 2;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HI,
        LO,
        TAIL
    } spi_state_t;

endpackage

// File: rtl/rbz_spi_shift_engine.sv
// SPI mode-0 shifter: sends LEN+1 bits MSB first; presents next-cycle SCLK/CS/MOSI for the caller to register.
// Latency: leaves IDLE on the start edge; frame occupies DIV*(2*(LEN+1)+1) cycles, done pulses on the return to IDLE.
// Backpressure: none; start is only honoured while idle.
module rbz_spi_shift_engine
    import rbz_spi_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [4:0]  i_len,
    input  logic [31:0] i_data,
    output logic        o_busy,
    output logic        o_done_pulse,
    output logic        o_sclk_nxt,
    output logic        o_cs_nxt,
    output logic        o_mosi_nxt
);

    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    spi_state_t    r_state, w_state;
    logic [CW-1:0] r_div, w_div;
    logic [4:0]    r_bits, w_bits;
    logic [31:0]   r_shift, w_shift;
    logic          w_done;

    // State, half-period counter, remaining-bit counter and left-aligned shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_bits  <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_bits  <= w_bits;
            r_shift <= w_shift;
        end
    end

    // Next state: every non-idle state lasts DIV cycles; the payload is left-aligned so bit 31 is always on the wire
    always_comb begin
        w_state = r_state;
        w_div   = r_div;
        w_bits  = r_bits;
        w_shift = r_shift;
        w_done  = 1'b0;
        if (r_state == IDLE) begin
            if (i_start) begin
                w_state = LEAD;
                w_div   = DIV_LAST;
                w_bits  = i_len;
                w_shift = i_data << (5'd31 - i_len);
            end
        end else if (r_div != '0) begin
            w_div = r_div - 1'b1;
        end else begin
            w_div = DIV_LAST;
            case (r_state)
                LEAD: w_state = HI;
                HI: begin
                    if (r_bits == '0) begin
                        w_state = TAIL;
                    end else begin
                        w_state = LO;
                        w_bits  = r_bits - 1'b1;
                        w_shift = r_shift << 1;
                    end
                end
                LO: w_state = HI;
                TAIL: begin
                    w_state = IDLE;
                    w_done  = 1'b1;
                end
                default: w_state = IDLE;
            endcase
        end
    end

    assign o_busy       = (r_state != IDLE);
    assign o_done_pulse = w_done;
    assign o_sclk_nxt   = (w_state == HI);
    assign o_cs_nxt     = (w_state != IDLE);
    assign o_mosi_nxt   = (w_state != IDLE) & w_shift[31];

endmodule

// File: rtl/rbz_spi_reg_master.sv
// Wishbone register front end for the SPI shifter, steering the frame to the raybox reg or vector SPI port.
// Latency: WB ack one cycle after a valid request; SS_N falls on the ack edge of a START write.
// Backpressure: none on WB; DATA/CTRL writes during a transfer are dropped and flagged in STATUS.OVR.
module rbz_spi_reg_master
    import rbz_spi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
    parameter int          DIV       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        o_reg_sclk,
    output logic        o_reg_mosi,
    output logic        o_reg_ss_n,
    output logic        o_vec_sclk,
    output logic        o_vec_mosi,
    output logic        o_vec_ss_n,
    output logic        o_irq
);

    logic        r_ack;
    logic [31:0] r_dat_o;
    logic [31:0] r_data;
    logic [4:0]  r_len;
    logic        r_tgt, r_ie, r_done, r_ovr;
    logic        r_reg_sclk, r_reg_mosi, r_reg_ss_n;
    logic        r_vec_sclk, r_vec_mosi, r_vec_ss_n;

    logic        w_valid, w_acc, w_wr, w_busy, w_done;
    logic        w_wr_data, w_wr_ctrl, w_wr_stat, w_start, w_tgt_eff;
    logic        w_sclk_nxt, w_cs_nxt, w_mosi_nxt;
    logic [1:0]  w_ofs;
    logic [4:0]  w_len_new;
    logic        w_tgt_new, w_ie_new;
    logic [31:0] w_data_new, w_rdat;
    logic        w_unused_adr;

    assign w_valid   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_acc     = w_valid & ~r_ack;
    assign w_wr      = w_acc & wbs_we_i;
    assign w_ofs     = wbs_adr_i[3:2];
    assign w_wr_data = w_wr & (w_ofs == OFS_DATA);
    assign w_wr_ctrl = w_wr & (w_ofs == OFS_CTRL);
    assign w_wr_stat = w_wr & (w_ofs == OFS_STATUS);
    assign w_len_new = wbs_sel_i[0] ? wbs_dat_i[4:0] : r_len;
    assign w_tgt_new = wbs_sel_i[1] ? wbs_dat_i[CTRL_TGT] : r_tgt;
    assign w_ie_new  = wbs_sel_i[1] ? wbs_dat_i[CTRL_IE] : r_ie;
    assign w_start   = w_wr_ctrl & ~w_busy & wbs_sel_i[3] & wbs_dat_i[CTRL_START];
    // The START write's own TGT must steer the very first frame cycle
    assign w_tgt_eff = w_start ? w_tgt_new : r_tgt;
    assign w_unused_adr = &{1'b0, wbs_adr_i[1:0]};

    rbz_spi_shift_engine #(.DIV(DIV)) u_engine (
        .clk          (clk),
        .reset        (reset),
        .i_start      (w_start),
        .i_len        (w_len_new),
        .i_data       (r_data),
        .o_busy       (w_busy),
        .o_done_pulse (w_done),
        .o_sclk_nxt   (w_sclk_nxt),
        .o_cs_nxt     (w_cs_nxt),
        .o_mosi_nxt   (w_mosi_nxt)
    );

    // Byte-lane merge for DATA writes and the read-back mux
    always_comb begin
        w_data_new = r_data;
        for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) w_data_new[8*b +: 8] = wbs_dat_i[8*b +: 8];
        end
        w_rdat = '0;
        case (w_ofs)
            OFS_DATA:   w_rdat = r_data;
            OFS_CTRL:   w_rdat = {22'd0, r_ie, r_tgt, 3'd0, r_len};
            OFS_STATUS: w_rdat = {29'd0, r_ovr, r_done, w_busy};
            default:    w_rdat = '0;
        endcase
    end

    // WB handshake: single-cycle ack and read data captured on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_dat_o <= '0;
        end else begin
            r_ack <= w_acc;
            if (w_acc) r_dat_o <= w_rdat;
        end
    end

    // Register file: DATA/CTRL locked while busy (overrun flagged), STATUS W1C with DONE set taking priority
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_len  <= '0;
            r_tgt  <= 1'b0;
            r_ie   <= 1'b0;
            r_done <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if ((w_wr_data | w_wr_ctrl) & w_busy) begin
                r_ovr <= 1'b1;
            end else if (w_wr_data) begin
                r_data <= w_data_new;
            end else if (w_wr_ctrl) begin
                r_len <= w_len_new;
                r_tgt <= w_tgt_new;
                r_ie  <= w_ie_new;
            end else if (w_wr_stat & wbs_sel_i[0] & wbs_dat_i[ST_OVR]) begin
                r_ovr <= 1'b0;
            end
            if (w_done) begin
                r_done <= 1'b1;
            end else if (w_wr_stat & wbs_sel_i[0] & wbs_dat_i[ST_DONE]) begin
                r_done <= 1'b0;
            end
        end
    end

    // SPI pins: engine's next values registered onto the selected port; the other port held idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_sclk <= 1'b0;
            r_reg_mosi <= 1'b0;
            r_reg_ss_n <= 1'b1;
            r_vec_sclk <= 1'b0;
            r_vec_mosi <= 1'b0;
            r_vec_ss_n <= 1'b1;
        end else begin
            r_reg_sclk <= w_sclk_nxt & ~w_tgt_eff;
            r_reg_mosi <= w_mosi_nxt & ~w_tgt_eff;
            r_reg_ss_n <= ~(w_cs_nxt & ~w_tgt_eff);
            r_vec_sclk <= w_sclk_nxt & w_tgt_eff;
            r_vec_mosi <= w_mosi_nxt & w_tgt_eff;
            r_vec_ss_n <= ~(w_cs_nxt & w_tgt_eff);
        end
    end

    assign wbs_ack_o  = r_ack;
    assign wbs_dat_o  = r_dat_o;
    assign o_reg_sclk = r_reg_sclk;
    assign o_reg_mosi = r_reg_mosi;
    assign o_reg_ss_n = r_reg_ss_n;
    assign o_vec_sclk = r_vec_sclk;
    assign o_vec_mosi = r_vec_mosi;
    assign o_vec_ss_n = r_vec_ss_n;
    assign o_irq      = r_done & r_ie;

endmodule

// File: tb/tb_rbz_spi_reg_master.sv
// Self-checking bench for rbz_spi_reg_master: directed scenarios plus random frames against a bit-list model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rbz_spi_reg_master;

    localparam int          DIV  = 2;
    localparam logic [31:0] BASE = 32'h3000_0100;
    localparam logic [31:0] A_DATA = BASE + 32'h0;
    localparam logic [31:0] A_CTRL = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;
    localparam logic [31:0] A_RSV  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        reg_sclk, reg_mosi, reg_ss_n, vec_sclk, vec_mosi, vec_ss_n, irq;

    int total = 0;
    int bad   = 0;

    rbz_spi_reg_master #(.BASE_ADDR(BASE), .DIV(DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .o_reg_sclk (reg_sclk),
        .o_reg_mosi (reg_mosi),
        .o_reg_ss_n (reg_ss_n),
        .o_vec_sclk (vec_sclk),
        .o_vec_mosi (vec_mosi),
        .o_vec_ss_n (vec_ss_n),
        .o_irq      (irq)
    );

    always #5 clk = ~clk;

    // Pin monitor, sampled on the falling edge: bits captured at SCLK rises, SS_N low cycles, any port activity
    bit rq[$];
    bit vq[$];
    int r_low = 0, v_low = 0;
    bit r_act = 0, v_act = 0;
    bit prev_rs = 0, prev_vs = 0;

    always @(negedge clk) begin
        if (!reg_ss_n) r_low++;
        if (!vec_ss_n) v_low++;
        if (reg_sclk && !prev_rs) rq.push_back(reg_mosi);
        if (vec_sclk && !prev_vs) vq.push_back(vec_mosi);
        if (reg_sclk || reg_mosi || !reg_ss_n) r_act = 1;
        if (vec_sclk || vec_mosi || !vec_ss_n) v_act = 1;
        prev_rs = reg_sclk;
        prev_vs = vec_sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mon_clear();
        rq.delete();
        vq.delete();
        r_low = 0;
        v_low = 0;
        r_act = 0;
        v_act = 0;
    endtask

    task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd);
        bit acked;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        acked = 0;
        rd = 'x;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1;
                rd = rdat;
            end
        end
        cyc = 0; stb = 0; we = 0;
        chk("wb_ack", 32'(acked), 32'd1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_cycle(a, 1'b1, d, s, dummy);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        wb_cycle(a, 1'b0, 32'h0, 4'hF, d);
    endtask

    task automatic xfer_start(input logic [31:0] d, input int len, input bit tgt, input bit ie);
        wr(A_DATA, d, 4'hF);
        mon_clear();
        wr(A_CTRL, 32'h8000_0000 | (32'(ie) << 9) | (32'(tgt) << 8) | 32'(len), 4'hF);
    endtask

    task automatic xfer_wait(input int len);
        repeat (DIV * (2 * (len + 1) + 1) + 4) @(posedge clk);
        #1;
    endtask

    // Model: a frame of n=len+1 bits is data[len] down to data[0], SS_N low for DIV*(2n+1) cycles
    task automatic xfer_check(input string tag, input logic [31:0] d, input int len,
                              input bit tgt, input logic [31:0] exp_stat);
        int          n;
        logic [63:0] obs_w, exp_w;
        logic [31:0] st;
        int          low, cnt;
        bit          idle_act;
        n = len + 1;
        obs_w = '0;
        if (tgt) begin
            foreach (vq[i]) obs_w = (obs_w << 1) | 64'(vq[i]);
            low = v_low; cnt = vq.size(); idle_act = r_act;
        end else begin
            foreach (rq[i]) obs_w = (obs_w << 1) | 64'(rq[i]);
            low = r_low; cnt = rq.size(); idle_act = v_act;
        end
        exp_w = 64'(d) & ((64'd1 << n) - 64'd1);
        chk({tag, "_ss_low"}, 32'(low), 32'(DIV * (2 * n + 1)));
        chk({tag, "_nbits"}, 32'(cnt), 32'(n));
        chk({tag, "_bits"}, obs_w[31:0], exp_w[31:0]);
        chk({tag, "_other_idle"}, 32'(idle_act), 32'd0);
        rd(A_STAT, st);
        chk({tag, "_status"}, st, exp_stat);
    endtask

    initial begin
        logic [31:0] v, d;
        int          len;
        bit          tgt, acked_any;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_reg_ss_n", 32'(reg_ss_n), 32'd1);
        chk("rst_vec_ss_n", 32'(vec_ss_n), 32'd1);
        chk("rst_sclk_mosi", {28'd0, reg_sclk, reg_mosi, vec_sclk, vec_mosi}, 32'd0);
        chk("rst_ack_irq", {30'd0, ack, irq}, 32'd0);
        chk("rst_dat_o", rdat, 32'd0);
        reset = 0;
        rd(A_DATA, v); chk("rst_data", v, 32'd0);
        rd(A_CTRL, v); chk("rst_ctrl", v, 32'd0);
        rd(A_STAT, v); chk("rst_status", v, 32'd0);

        // Byte-granular DATA write
        wr(A_DATA, 32'hFFFF_FFFF, 4'hF);
        wr(A_DATA, 32'h1234_5678, 4'b0101);
        rd(A_DATA, v); chk("sel_merge", v, 32'hFF34_FF78);

        // 8-bit frame on the register port
        xfer_start(32'h0000_00A5, 7, 0, 0);
        xfer_wait(7);
        xfer_check("t1", 32'h0000_00A5, 7, 0, 32'h2);
        rd(A_CTRL, v); chk("t1_ctrl_rb", v, 32'h0000_0007);
        wr(A_STAT, 32'h6, 4'hF);

        // 32-bit frame on the vector port
        xfer_start(32'h8000_0001, 31, 1, 0);
        xfer_wait(31);
        xfer_check("t2", 32'h8000_0001, 31, 1, 32'h2);
        wr(A_STAT, 32'h6, 4'hF);

        // Interrupt, busy read mid-frame, W1C of DONE
        xfer_start(32'h0000_005A, 7, 1, 1);
        rd(A_STAT, v); chk("t3_busy_mid", v, 32'h1);
        chk("t3_irq_mid", 32'(irq), 32'd0);
        xfer_wait(7);
        chk("t3_irq_done", 32'(irq), 32'd1);
        xfer_check("t3", 32'h0000_005A, 7, 1, 32'h2);
        wr(A_STAT, 32'h2, 4'hF);
        chk("t3_irq_clr", 32'(irq), 32'd0);
        rd(A_STAT, v); chk("t3_status_clr", v, 32'h0);

        // Overrun: DATA write while busy is dropped
        xfer_start(32'h0000_003C, 7, 0, 0);
        wr(A_DATA, 32'h0000_00FF, 4'hF);
        rd(A_STAT, v); chk("t4_ovr_mid", v, 32'h5);
        xfer_wait(7);
        xfer_check("t4", 32'h0000_003C, 7, 0, 32'h6);
        rd(A_DATA, v); chk("t4_data_kept", v, 32'h0000_003C);
        wr(A_STAT, 32'h6, 4'hF);
        rd(A_STAT, v); chk("t4_status_clr", v, 32'h0);

        // Out-of-window access gets no ack and writes nothing; reserved offset acks with 0
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'h40; wdat = 32'hDEAD_BEEF; sel = 4'hF;
        acked_any = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) acked_any = 1;
        end
        cyc = 0; stb = 0; we = 0;
        chk("t6_no_ack", 32'(acked_any), 32'd0);
        rd(A_DATA, v); chk("t6_data_untouched", v, 32'h0000_003C);
        wr(A_RSV, 32'hFFFF_FFFF, 4'hF);
        rd(A_RSV, v); chk("t6_rsv_zero", v, 32'h0);

        // Reset in the middle of a 16-bit frame
        xfer_start(32'h0000_F00D, 15, 0, 1);
        for (int i = 0; i < 200 && rq.size() < 3; i++) begin
            @(posedge clk); #1;
        end
        chk("t5_reached_bit3", 32'(rq.size() >= 3), 32'd1);
        reset = 1;
        @(posedge clk); #1;
        chk("t5_ss_n", {30'd0, reg_ss_n, vec_ss_n}, 32'h3);
        chk("t5_sclk", {30'd0, reg_sclk, vec_sclk}, 32'h0);
        reset = 0;
        repeat (80) @(posedge clk);
        #1;
        chk("t5_irq", 32'(irq), 32'd0);
        chk("t5_ss_n_after", {30'd0, reg_ss_n, vec_ss_n}, 32'h3);
        rd(A_STAT, v); chk("t5_status", v, 32'h0);
        rd(A_CTRL, v); chk("t5_ctrl", v, 32'h0);

        // Random frames
        for (int k = 0; k < 8; k++) begin
            d   = $urandom;
            len = int'($urandom_range(0, 31));
            tgt = bit'($urandom_range(0, 1));
            xfer_start(d, len, tgt, 0);
            xfer_wait(len);
            xfer_check($sformatf("rnd%0d", k), d, len, tgt, 32'h2);
            rd(A_CTRL, v);
            chk($sformatf("rnd%0d_ctrl", k), v, (32'(tgt) << 8) | 32'(len));
            wr(A_STAT, 32'h6, 4'hF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
